restoring_divider: RTL

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 107 ++++++++++
 1 files changed

// File: rtl/restoring_divider.sv
// Unsigned multi-cycle restoring divider, one quotient bit per clock.
// Ports: clk, rst (async high), Data_in_Start/A/B in; Quotient, Remainder, Busy, Done, DivZero out.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Data_in_Start,
  input  logic [WIDTH-1:0] Data_in_A,
  input  logic [WIDTH-1:0] Data_in_B,
  output logic [WIDTH-1:0] Data_out_Quotient,
  output logic [WIDTH-1:0] Data_out_Remainder,
  output logic             Data_out_Busy,
  output logic             Data_out_Done,
  output logic             Data_out_DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, next;

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             zero_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] prem_nxt;
  logic [WIDTH-1:0] dvd_nxt;

  assign accept = Data_in_Start && (state != RUN);
  assign zero_b = (Data_in_B == '0);

  // dvd doubles as the quotient shift register: dividend bits
  // leave at the top while quotient bits enter at the bottom.
  assign shifted  = {prem, dvd[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign qbit     = ~diff[WIDTH];
  assign prem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_nxt  = {dvd[WIDTH-2:0], qbit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) next = zero_b ? DONE : RUN;
        else        next = IDLE;
      end
      RUN: begin
        if (cnt == CW'(1)) next = DONE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd                <= '0;
      dvs                <= '0;
      prem               <= '0;
      cnt                <= '0;
      Data_out_Quotient  <= '0;
      Data_out_Remainder <= '0;
      Data_out_DivZero   <= 1'b0;
    end else if (accept) begin
      dvd  <= Data_in_A;
      dvs  <= Data_in_B;
      prem <= '0;
      if (zero_b) begin
        cnt                <= '0;
        Data_out_Quotient  <= '1;
        Data_out_Remainder <= Data_in_A;
        Data_out_DivZero   <= 1'b1;
      end else begin
        cnt <= CW'(WIDTH);
      end
    end else if (state == RUN) begin
      prem <= prem_nxt;
      dvd  <= dvd_nxt;
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        Data_out_Quotient  <= dvd_nxt;
        Data_out_Remainder <= prem_nxt;
        Data_out_DivZero   <= 1'b0;
      end
    end
  end

  assign Data_out_Busy = (state == RUN);
  assign Data_out_Done = (state == DONE);

endmodule
